mult_div_unit: RTL and testbench

Iterative-latency multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and raises `MULT_DIV_BUSY` for the fixed operation latency. The hazard controller consumes `MULT_DIV_BUSY`, together with its own decoded start indication, to stall any HI/LO-using instruction in ID. The unit also supplies HI/LO read data for MFHI/MFLO in EX.

---
 rtl/mult_div_unit_if.sv | 22 ++
 rtl/mult_div_unit.sv | 105 ++++++++++
 tb/tb_mult_div_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// EX-stage request and response bundle for the multiply/divide unit.
// The master is the EX stage; the slave is mult_div_unit.
interface mult_div_unit_if;
  logic        MD_Start;
  logic [2:0]  MD_Op;
  logic [31:0] MD_A;
  logic [31:0] MD_B;
  logic        MD_Cancel;
  logic        MD_ReadHi;
  logic        MULT_DIV_BUSY;
  logic [31:0] MD_Out;

  modport master (
    output MD_Start, MD_Op, MD_A, MD_B, MD_Cancel, MD_ReadHi,
    input  MULT_DIV_BUSY, MD_Out
  );

  modport slave (
    input  MD_Start, MD_Op, MD_A, MD_B, MD_Cancel, MD_ReadHi,
    output MULT_DIV_BUSY, MD_Out
  );
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit with architectural HI/LO registers.
// Results are computed at accept, held in P_HI/P_LO, and committed when the countdown expires.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_div_unit_if.slave md
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } md_op_e;

  logic [3:0]  cnt;
  logic [31:0] hi, lo, p_hi, p_lo;

  md_op_e      op;
  logic        accept;
  logic [31:0] a, b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, uq, ur, sq, sr, dq, dr;
  logic [31:0] hi_now, lo_now;

  always_comb begin
    op     = md_op_e'(md.MD_Op);
    a      = md.MD_A;
    b      = md.MD_B;
    // cnt==1 is the commit edge, where a back-to-back start is allowed in
    accept = md.MD_Start && !md.MD_Cancel && (cnt <= 4'd1);

    // Low 64 bits of the product of sign-extended operands equal the signed product
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes keeps 0x80000000 / -1 well defined
    abs_a = a[31] ? -a : a;
    abs_b = b[31] ? -b : b;
    uq    = (abs_b == '0) ? '0 : abs_a / abs_b;
    ur    = (abs_b == '0) ? '0 : abs_a % abs_b;
    sq    = (a[31] ^ b[31]) ? -uq : uq;
    sr    = a[31] ? -ur : ur;

    dq    = (b == '0) ? '0 : a / b;
    dr    = (b == '0) ? '0 : a % b;

    // Divide-by-zero preserves the architectural value as of this edge, including a same-edge commit
    hi_now = (cnt == 4'd1) ? p_hi : hi;
    lo_now = (cnt == 4'd1) ? p_lo : lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      p_hi <= '0;
      p_lo <= '0;
    end else begin
      if (cnt == 4'd1) begin
        hi <= p_hi;
        lo <= p_lo;
      end
      if (cnt != '0) cnt <= cnt - 4'd1;

      if (accept) begin
        case (op)
          OP_MULT: begin
            {p_hi, p_lo} <= prod_s;
            cnt          <= 4'(MULT_CYCLES);
          end
          OP_MULTU: begin
            {p_hi, p_lo} <= prod_u;
            cnt          <= 4'(MULT_CYCLES);
          end
          OP_DIV: begin
            p_hi <= (b == '0) ? hi_now : sr;
            p_lo <= (b == '0) ? lo_now : sq;
            cnt  <= 4'(DIV_CYCLES);
          end
          OP_DIVU: begin
            p_hi <= (b == '0) ? hi_now : dr;
            p_lo <= (b == '0) ? lo_now : dq;
            cnt  <= 4'(DIV_CYCLES);
          end
          OP_MTHI: hi <= a;
          OP_MTLO: lo <= a;
          default: ;
        endcase
      end
    end
  end

  assign md.MULT_DIV_BUSY = (cnt != '0);
  assign md.MD_Out        = md.MD_ReadHi ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of single operations plus
// cancel, back-to-back and mid-operation reset sequences.
module tb_mult_div_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mult_div_unit_if ifc ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    ifc.MD_ReadHi = 1'b1;
    #1 h = ifc.MD_Out;
    ifc.MD_ReadHi = 1'b0;
    #1 l = ifc.MD_Out;
  endtask

  // Drive one start for exactly one edge; a start over a busy unit is a hazard-controller bug
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel);
    @(negedge clk);
    ifc.MD_Start  = 1'b1;
    ifc.MD_Op     = op;
    ifc.MD_A      = a;
    ifc.MD_B      = b;
    ifc.MD_Cancel = cancel;
    assert (!ifc.MULT_DIV_BUSY) else begin
      n_fail++;
      $error("FAIL start_while_busy: got busy=1 required busy=0");
    end
    @(posedge clk);
    #1;
    ifc.MD_Start  = 1'b0;
    ifc.MD_Cancel = 1'b0;
    ifc.MD_Op     = 3'b000;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (ifc.MULT_DIV_BUSY && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, l;
    int          nb;
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    ifc.MD_Start  = 1'b0;
    ifc.MD_Op     = 3'b000;
    ifc.MD_A      = '0;
    ifc.MD_B      = '0;
    ifc.MD_Cancel = 1'b0;
    ifc.MD_ReadHi = 1'b0;

    vecs[0]  = '{"mult_neg",     3'd1, 32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu_max",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"div_neg",      3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"div_ovf",      3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[4]  = '{"div_pos_neg",  3'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[5]  = '{"divu",         3'd4, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
    vecs[6]  = '{"mult_pos_max", 3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
    vecs[7]  = '{"mthi",         3'd5, 32'h00000011, 32'hDEADBEEF, 0,  32'h00000011, 32'h00000001};
    vecs[8]  = '{"mtlo",         3'd6, 32'h00000022, 32'h00000000, 0,  32'h00000011, 32'h00000022};
    vecs[9]  = '{"divu_zero",    3'd4, 32'h00000005, 32'h00000000, 10, 32'h00000011, 32'h00000022};
    vecs[10] = '{"div_zero",     3'd3, 32'hFFFFFFF0, 32'h00000000, 10, 32'h00000011, 32'h00000022};
    vecs[11] = '{"nop0",         3'd0, 32'h12345678, 32'h00000001, 0,  32'h00000011, 32'h00000022};
    vecs[12] = '{"nop7",         3'd7, 32'h12345678, 32'h00000001, 0,  32'h00000011, 32'h00000022};

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(ifc.MULT_DIV_BUSY), 32'd0);
    read_hilo(h, l);
    check("reset_hi", h, 32'd0);
    check("reset_lo", l, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      count_busy(nb);
      check({vecs[i].name, "_busy"}, 32'(nb), 32'(vecs[i].busy));
      read_hilo(h, l);
      check({vecs[i].name, "_hi"}, h, vecs[i].hi);
      check({vecs[i].name, "_lo"}, l, vecs[i].lo);
    end

    // Cancelled MULT: nothing latched, no busy
    issue(3'd1, 32'h00000003, 32'h00000004, 1'b1);
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ifc.MULT_DIV_BUSY) nb++;
    end
    check("cancel_busy", 32'(nb), 32'd0);
    read_hilo(h, l);
    check("cancel_hi", h, 32'h00000011);
    check("cancel_lo", l, 32'h00000022);

    // Back-to-back: MULTU 2x3, then DIVU 100/7 on the commit edge
    issue(3'd2, 32'd2, 32'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_mult_busy", 32'(ifc.MULT_DIV_BUSY), 32'd1);
    end
    @(negedge clk);
    check("b2b_last_busy", 32'(ifc.MULT_DIV_BUSY), 32'd1);
    ifc.MD_Start = 1'b1;
    ifc.MD_Op    = 3'd4;
    ifc.MD_A     = 32'd100;
    ifc.MD_B     = 32'd7;
    @(posedge clk);
    #1;
    ifc.MD_Start = 1'b0;
    ifc.MD_Op    = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("b2b_div_busy", 32'(ifc.MULT_DIV_BUSY), 32'd1);
      read_hilo(h, l);
      check("b2b_mid_hi", h, 32'd0);
      check("b2b_mid_lo", l, 32'd6);
    end
    @(negedge clk);
    check("b2b_end_busy", 32'(ifc.MULT_DIV_BUSY), 32'd0);
    read_hilo(h, l);
    check("b2b_final_hi", h, 32'd2);
    check("b2b_final_lo", l, 32'd14);

    // Asynchronous reset in busy cycle 3 of a DIV
    issue(3'd3, 32'd100, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(ifc.MULT_DIV_BUSY), 32'd0);
    read_hilo(h, l);
    check("rst_mid_hi", h, 32'd0);
    check("rst_mid_lo", l, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifc.MULT_DIV_BUSY) nb++;
    end
    check("rst_after_busy", 32'(nb), 32'd0);
    read_hilo(h, l);
    check("rst_after_hi", h, 32'd0);
    check("rst_after_lo", l, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
